// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file write-port arbiter.
// Default widths and the arbitration FSM state encoding.
package regfile_ctrl_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending mult/div destination tracker with set-over-clear priority.
// Register 0 is never busy.
module regfile_scoreboard
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_reg,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_reg,
    input  logic [ADDR_W-1:0] rs_query,
    input  logic [ADDR_W-1:0] rt_query,
    output logic              rs_hit,
    output logic              rt_hit
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_reg] = 1'b1;
        if (clr_en) clr_vec[clr_reg] = 1'b1;
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
    end

    // A set in the same cycle as a clear keeps the bit busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= set_vec | (busy_q & ~clr_vec);
        end
    end

    assign rs_hit = busy_q[rs_query];
    assign rt_hit = busy_q[rt_query];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB and mult/div,
// with a starvation guard that freezes the pipe for one md commit.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    input  logic              md_issue,
    input  logic [ADDR_W-1:0] md_issue_reg,
    input  logic [ADDR_W-1:0] rs_query,
    input  logic [ADDR_W-1:0] rt_query,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              pipe_stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Writeregister,
    output logic [DATA_W-1:0] Writedata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;

    logic wb_req;
    logic md_req;
    logic wb_win;
    logic md_win;
    logic md_hs;
    logic src_md_q;
    logic sb_rs;
    logic sb_rt;

    assign wb_req = wb_we && (wb_reg != '0);
    assign md_req = md_valid && (md_reg != '0);

    always_comb begin
        md_ready = 1'b0;
        wb_win   = 1'b0;
        md_win   = 1'b0;
        if (state == FORCE) begin
            md_ready = md_valid;
            md_win   = md_req;
        end else begin
            md_ready = md_valid && (!wb_req || (md_reg == '0));
            wb_win   = wb_req;
            md_win   = md_req && !wb_req;
        end
    end

    assign md_hs      = md_valid && md_ready;
    assign pipe_stall = (state == FORCE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (md_valid && !md_ready) begin
                        state    <= WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (md_hs || !md_valid) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt >= LIMIT_M1) begin
                        state <= FORCE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                FORCE: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Index and data hold their last values when the port is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            Writeregister <= '0;
            Writedata     <= '0;
            src_md_q      <= 1'b0;
        end else begin
            RegWrite <= wb_win || md_win;
            src_md_q <= md_win;
            if (md_win) begin
                Writeregister <= md_reg;
                Writedata     <= md_data;
            end else if (wb_win) begin
                Writeregister <= wb_reg;
                Writedata     <= wb_data;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (md_issue),
        .set_reg  (md_issue_reg),
        .clr_en   (md_hs),
        .clr_reg  (md_reg),
        .rs_query (rs_query),
        .rt_query (rt_query),
        .rs_hit   (sb_rs),
        .rt_hit   (sb_rt)
    );

    // Cover the cycle after the clear, before the file holds the value.
    assign rs_busy = sb_rs || (RegWrite && src_md_q &&
                     (Writeregister == rs_query) && (rs_query != '0));
    assign rt_busy = sb_rt || (RegWrite && src_md_q &&
                     (Writeregister == rt_query) && (rt_query != '0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter.
// Reference model tracks blocked-cycle count, busy set and port contents.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_we;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          md_valid;
    logic [AW-1:0] md_reg;
    logic [DW-1:0] md_data;
    logic          md_ready;
    logic          md_issue;
    logic [AW-1:0] md_issue_reg;
    logic [AW-1:0] rs_query;
    logic [AW-1:0] rt_query;
    logic          rs_busy;
    logic          rt_busy;
    logic          pipe_stall;
    logic          RegWrite;
    logic [AW-1:0] Writeregister;
    logic [DW-1:0] Writedata;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_we         (wb_we),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .md_valid      (md_valid),
        .md_reg        (md_reg),
        .md_data       (md_data),
        .md_ready      (md_ready),
        .md_issue      (md_issue),
        .md_issue_reg  (md_issue_reg),
        .rs_query      (rs_query),
        .rt_query      (rt_query),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .pipe_stall    (pipe_stall),
        .RegWrite      (RegWrite),
        .Writeregister (Writeregister),
        .Writedata     (Writedata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit            busy_m [32];
    int            blocked;
    logic          m_we;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;
    logic          m_src;
    logic          last_hs;
    logic          last_rst;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_force();
        return blocked >= SL;
    endfunction

    function automatic logic m_ready();
        logic wbr;
        wbr = wb_we && (wb_reg != 0);
        if (m_force()) return md_valid;
        return md_valid && (!wbr || md_reg == 0);
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] q);
        if (q == 0) return 1'b0;
        return busy_m[q] || (m_we && m_src && m_reg == q);
    endfunction

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        blocked  = 0;
        m_we     = 1'b0;
        m_reg    = '0;
        m_data   = '0;
        m_src    = 1'b0;
        last_hs  = 1'b0;
        last_rst = 1'b0;
    endtask

    task automatic tick();
        logic frc, rdy, hs, wbr, mdr, ww, mw;
        @(negedge clk);
        check("md_ready", md_ready, m_ready());
        check("pipe_stall", pipe_stall, m_force());
        check("rs_busy", rs_busy, m_busy(rs_query));
        check("rt_busy", rt_busy, m_busy(rt_query));
        check("RegWrite", RegWrite, m_we);
        check("Writeregister", Writeregister, m_reg);
        check("Writedata", Writedata, m_data);
        @(posedge clk);
        frc = m_force();
        rdy = m_ready();
        hs  = md_valid && rdy;
        if (!rst_n) begin
            model_reset();
        end else begin
            wbr = wb_we && (wb_reg != 0);
            mdr = md_valid && (md_reg != 0);
            if (frc) begin
                ww = 1'b0;
                mw = mdr && hs;
            end else begin
                ww = wbr;
                mw = mdr && !wbr;
            end
            m_we  = ww || mw;
            m_src = mw;
            if (mw) begin
                m_reg  = md_reg;
                m_data = md_data;
            end else if (ww) begin
                m_reg  = wb_reg;
                m_data = wb_data;
            end
            if (hs && md_reg != 0) busy_m[md_reg] = 1'b0;
            if (md_issue && md_issue_reg != 0) busy_m[md_issue_reg] = 1'b1;
            if (frc || !md_valid || hs) blocked = 0;
            else blocked++;
            last_hs  = hs;
            last_rst = 1'b1;
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst_n        = 1'b0;
        wb_we        = 1'($urandom);
        wb_reg       = 5'($urandom);
        wb_data      = $urandom;
        md_valid     = 1'($urandom);
        md_reg       = 5'($urandom);
        md_data      = $urandom;
        md_issue     = 1'($urandom);
        md_issue_reg = 5'($urandom);
        rs_query     = 5'($urandom);
        rt_query     = 5'($urandom);
        @(posedge clk);
        #1;
        tick();
        tick();
        check("reset_regwrite", RegWrite, 1'b0);
        check("reset_wreg", Writeregister, 5'd0);
        check("reset_wdata", Writedata, 32'd0);
        check("reset_stall", pipe_stall, 1'b0);

        rst_n    = 1'b1;
        md_valid = 1'b0;
        md_issue = 1'b0;
        rs_query = 5'd0;
        rt_query = 5'd0;
        wb_we    = 1'b1;
        wb_reg   = 5'd8;
        wb_data  = 32'h1234;
        tick();
        check("wb_we", RegWrite, 1'b1);
        check("wb_reg", Writeregister, 5'd8);
        check("wb_data", Writedata, 32'h1234);
        wb_reg = 5'd0;
        tick();
        check("wb_r0_none", RegWrite, 1'b0);

        wb_reg   = 5'd3;
        wb_data  = 32'h3333;
        md_valid = 1'b1;
        md_reg   = 5'd9;
        md_data  = 32'hBEEF;
        for (int i = 0; i < SL; i++) begin
            #1;
            check("starve_blocked", md_ready, 1'b0);
            tick();
        end
        #1;
        check("force_stall", pipe_stall, 1'b1);
        check("force_ready", md_ready, 1'b1);
        tick();
        md_valid = 1'b0;
        check("force_wreg", Writeregister, 5'd9);
        check("force_wdata", Writedata, 32'hBEEF);
        tick();
        wb_we = 1'b0;
        check("replay_wreg", Writeregister, 5'd3);
        check("replay_wdata", Writedata, 32'h3333);

        md_issue     = 1'b1;
        md_issue_reg = 5'd10;
        rs_query     = 5'd10;
        tick();
        md_issue = 1'b0;
        #1;
        check("sb_set", rs_busy, 1'b1);
        tick();
        md_valid = 1'b1;
        md_reg   = 5'd10;
        md_data  = 32'hA0A0;
        #1;
        check("sb_commit_cyc", rs_busy, 1'b1);
        tick();
        md_valid = 1'b0;
        #1;
        check("sb_write_cyc", rs_busy, 1'b1);
        tick();
        check("sb_cleared", rs_busy, 1'b0);

        md_issue     = 1'b1;
        md_issue_reg = 5'd11;
        rt_query     = 5'd11;
        tick();
        md_valid = 1'b1;
        md_reg   = 5'd11;
        md_data  = 32'h1111;
        tick();
        md_valid = 1'b0;
        md_issue = 1'b0;
        tick();
        check("set_wins", rt_busy, 1'b1);

        md_valid = 1'b1;
        md_reg   = 5'd0;
        md_data  = 32'hDEAD;
        #1;
        check("md_r0_ready", md_ready, 1'b1);
        tick();
        md_valid = 1'b0;
        check("md_r0_nowrite", RegWrite, 1'b0);

        wb_we    = 1'b1;
        wb_reg   = 5'd4;
        md_valid = 1'b1;
        md_reg   = 5'd12;
        md_data  = 32'hC0DE;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        md_valid = 1'b0;
        wb_we    = 1'b0;
        #1;
        check("rst_wait_ready", md_ready, 1'b0);
        check("rst_wait_stall", pipe_stall, 1'b0);
        tick();

        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 63) != 0);
            wb_we   = ($urandom_range(0, 3) != 0);
            wb_reg  = 5'($urandom);
            wb_data = $urandom;
            if (!(md_valid && !last_hs && last_rst)) begin
                md_valid = ($urandom_range(0, 2) == 0);
                md_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                md_data  = $urandom;
            end
            md_issue     = ($urandom_range(0, 3) == 0);
            md_issue_reg = 5'($urandom);
            case ($urandom_range(0, 2))
                0:       rs_query = md_reg;
                1:       rs_query = Writeregister;
                default: rs_query = 5'($urandom);
            endcase
            rt_query = ($urandom_range(0, 1) == 0) ? md_issue_reg : 5'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 register file (Writeregister/Writedata/RegWrite) between two writers. The writers are the pipeline WB stage and the multi-cycle mult/div unit. Holds a scoreboard of registers with outstanding mult/div results so decode can stall on them. Includes a starvation guard that briefly freezes the pipeline so a blocked mult/div result can commit. Sits between the WB stage, the mult/div unit, hazard detection and the register file.

Parameters:
ADDR_W, 5, register index width (32 registers)
DATA_W, 32, register data width
STARVE_LIMIT, 4, cycles mult/div may be blocked before a forced slot (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
wb_we  in  1  pipeline WB write request (cannot be back-pressured except via pipe_stall)
wb_reg  in  ADDR_W  WB destination register
wb_data  in  DATA_W  WB write data
md_valid  in  1  mult/div result valid
md_reg  in  ADDR_W  mult/div destination register
md_data  in  DATA_W  mult/div result
md_ready  out  1  mult/div result accepted this cycle
md_issue  in  1  mult/div op issued from decode this cycle
md_issue_reg  in  ADDR_W  destination of issued op
rs_query  in  ADDR_W  decode rs index
rt_query  in  ADDR_W  decode rt index
rs_busy  out  1  rs has a pending mult/div result
rt_busy  out  1  rt has a pending mult/div result
pipe_stall  out  1  freeze pipeline (IF..WB) this cycle
RegWrite  out  1  register file write enable
Writeregister  out  ADDR_W  register file write index
Writedata  out  DATA_W  register file write data

Behaviour:
- Reset (rst_n=0 at edge): RegWrite=0, Writeregister=0, Writedata=0. Scoreboard cleared, state=IDLE, wait_cnt=0. pipe_stall=0 and md_ready=0 follow from state IDLE with no request.
- Reset mid-operation drops any unaccepted md result. The mult/div unit is reset by the same rst_n.
- Effective requests:
  - wb_req = wb_we && wb_reg!=0.
  - md_req = md_valid && md_reg!=0.
  - md_valid with md_reg==0 is accepted (md_ready=1) and discarded, with no port write.
- Grant (combinational):
  - In IDLE/WAIT: WB wins. md_ready = md_valid && (!wb_req || md_reg==0).
  - In FORCE: md wins. md_ready = md_valid. The frozen WB stage re-presents its request next cycle.
- Write port is registered, latency 1. The winning request in cycle N drives RegWrite/Writeregister/Writedata in cycle N+1. The register file writes at the end of N+1.
- With no winner, RegWrite=0 next cycle and Writeregister/Writedata hold their values.
- src_md_q: registered flag, 1 when the current port write came from md.
- md protocol: md_reg and md_data stay stable while md_valid=1 and md_ready=0. Handshake = md_valid && md_ready.
- FSM:
  - IDLE -> WAIT when md_valid && !md_ready.
  - WAIT: wait_cnt increments each blocked cycle. Handshake -> IDLE with wait_cnt=0. Blocked with wait_cnt==STARVE_LIMIT-1 -> FORCE.
  - FORCE: lasts exactly 1 cycle, pipe_stall=1, md commits. -> IDLE, wait_cnt=0.
  - pipe_stall=1 only in FORCE.
- Scoreboard (busy[31:1], busy[0] hardwired 0):
  - md_issue sets busy[md_issue_reg].
  - md handshake clears busy[md_reg].
  - Same register set and cleared in the same cycle: set wins.
- Busy outputs:
  - rs_busy = busy[rs_query] || (RegWrite && src_md_q && Writeregister==rs_query && rs_query!=0). rt_busy is the same with rt_query.
  - This covers the cycle between clear and the register-file write.
- Issuing to an already-busy register is a decode protocol violation. Busy stays 1 and no checking is performed.

Decomposition:
- Package regfile_ctrl_pkg: ADDR_W/DATA_W defaults, FSM state enum {IDLE, WAIT, FORCE}.
- Sub-module regfile_scoreboard: busy vector, set/clear with set priority, two combinational query ports.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> RegWrite=0, Writeregister=0, Writedata=0, pipe_stall=0, rs_busy=rt_busy=0.
- WB only: wb_we=1, wb_reg=8, wb_data=0x1234 in cycle N -> RegWrite=1, Writeregister=8, Writedata=0x1234 in N+1. wb_reg=0 -> RegWrite=0.
- Contention: wb_req every cycle plus md_valid (reg 9, 0xBEEF), STARVE_LIMIT=4:
  - md_ready=0 for 4 cycles.
  - 5th cycle: pipe_stall=1, md_ready=1.
  - Next cycle: Writeregister=9, Writedata=0xBEEF.
  - The stalled WB write appears one cycle after that.
- Scoreboard: md_issue reg 10 -> rs_query=10 gives rs_busy=1. Keep rs_busy=1 through the md commit cycle and the following RegWrite cycle; rs_busy=0 after.
- Simultaneous set/clear: md handshake on reg 11 while md_issue reg 11 in the same cycle -> busy[11] remains 1.
- md_reg=0: md_valid=1, md_reg=0 -> md_ready=1, RegWrite stays 0. Mid-WAIT reset -> state IDLE, md_ready=0 after reset.
